// File: rtl/mlp_backprop_engine.sv
// mlp_backprop_engine: sequential SGD step for an N_IN->N_HID(ReLU)->N_OUT(softmax) classifier
// Owns W0/b0/W1/b1 and drives them out flat and row-major (W0[j][i], b0[j], W1[k][j], b1[k]).
// Ports: clk, rst (sync, active-high)
//   start/skip_hit/lr_shift/predictedstate/realstate : step request and its controls
//   x_in/hiddenlayerout/softmaxout                    : forward-pass vectors, latched on accept
//   wr_en/wr_addr/wr_data                             : idle-time parameter preload
//   W0/b0/W1/b1                                       : live parameter registers
//   busy/done/err                                     : step status (done/err are one-cycle pulses)
module mlp_backprop_engine #(
  parameter int DATAWIDTH = 16,
  parameter int FRAC      = 10,
  parameter int N_IN      = 2,
  parameter int N_HID     = 8,
  parameter int N_OUT     = 3,
  localparam int SW = $clog2(N_OUT),
  localparam int AW = $clog2(N_HID*N_IN + N_HID + N_OUT*N_HID + N_OUT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             skip_hit,
  input  logic [3:0]                       lr_shift,
  input  logic [SW-1:0]                    predictedstate,
  input  logic [SW-1:0]                    realstate,
  input  logic [N_IN*DATAWIDTH-1:0]        x_in,
  input  logic [N_HID*DATAWIDTH-1:0]       hiddenlayerout,
  input  logic [N_OUT*DATAWIDTH-1:0]       softmaxout,
  input  logic                             wr_en,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [DATAWIDTH-1:0]             wr_data,
  output logic [N_HID*N_IN*DATAWIDTH-1:0]  W0,
  output logic [N_HID*DATAWIDTH-1:0]       b0,
  output logic [N_OUT*N_HID*DATAWIDTH-1:0] W1,
  output logic [N_OUT*DATAWIDTH-1:0]       b1,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  localparam int DW  = DATAWIDTH;
  localparam int N0  = N_HID*N_IN;
  localparam int N1  = N_OUT*N_HID;
  localparam int PW  = 2*DW;
  localparam int ACW = 2*DW + SW;
  localparam int WW  = ACW + 2;
  localparam int CW  = $clog2(N_HID + N_OUT + N_IN + 2);
  localparam logic signed [DW-1:0] ONE  = DW'(2**FRAC);
  localparam logic signed [WW-1:0] MAXV = WW'(2**(DW-1) - 1);
  localparam logic signed [WW-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {IDLE, CHK, DZ1, DA0, UPD1, UPD0, DONE} state_t;
  typedef logic signed [DW-1:0] word_t;
  state_t state_q, state_d;
  logic [CW-1:0] o_q, o_d, i_q, i_d;
  logic signed [ACW-1:0] acc_q, acc_d, acc_n;
  word_t w0_q[N0], w0_d[N0], b0_q[N_HID], b0_d[N_HID];
  word_t w1_q[N1], w1_d[N1], b1_q[N_OUT], b1_d[N_OUT];
  word_t x_q[N_IN], x_d[N_IN], h_q[N_HID], h_d[N_HID], sm_q[N_OUT], sm_d[N_OUT];
  word_t dz1_q[N_OUT], dz1_d[N_OUT], dz0_q[N_HID], dz0_d[N_HID];
  logic [SW-1:0] real_q, real_d;
  logic [3:0] lr_q, lr_d;
  logic err_q, err_d, byp_q, byp_d;
  word_t op_a, op_b, old_v, upd;
  logic signed [PW-1:0] prod;
  int oi, ii, wa;
  function automatic word_t sat(input logic signed [WW-1:0] v);
    return v > MAXV ? MAXV[DW-1:0] : v < MINV ? MINV[DW-1:0] : v[DW-1:0];
  endfunction
  // Shared MAC: the bias column multiplies by ONE so (dz*ONE)>>>(FRAC+lr) == dz>>>lr.
  always_comb begin
    oi = int'(o_q);
    ii = int'(i_q);
    op_a = '0;
    op_b = '0;
    old_v = '0;
    if (state_q == DA0) begin
      op_a = w1_q[ii*N_HID + oi];
      op_b = dz1_q[ii];
    end else if (state_q == UPD1) begin
      op_a = dz1_q[oi];
      op_b = ii == N_HID ? ONE : h_q[ii];
      old_v = ii == N_HID ? b1_q[oi] : w1_q[oi*N_HID + ii];
    end else if (state_q == UPD0) begin
      op_a = dz0_q[oi];
      op_b = ii == N_IN ? ONE : x_q[ii];
      old_v = ii == N_IN ? b0_q[oi] : w0_q[oi*N_IN + ii];
    end
    prod = PW'(op_a) * PW'(op_b);
    upd = sat(WW'(old_v) - (WW'(prod) >>> (FRAC + int'(lr_q))));
  end
  always_comb begin
    state_d = state_q;
    o_d = o_q;
    i_d = i_q;
    acc_d = acc_q;
    acc_n = acc_q + ACW'(prod);
    w0_d = w0_q;
    b0_d = b0_q;
    w1_d = w1_q;
    b1_d = b1_q;
    x_d = x_q;
    h_d = h_q;
    sm_d = sm_q;
    dz1_d = dz1_q;
    dz0_d = dz0_q;
    real_d = real_q;
    lr_d = lr_q;
    err_d = err_q;
    byp_d = byp_q;
    wa = int'(wr_addr);
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (wa < N0) w0_d[wa] = wr_data;
          else if (wa < N0 + N_HID) b0_d[wa - N0] = wr_data;
          else if (wa < N0 + N_HID + N1) w1_d[wa - N0 - N_HID] = wr_data;
          else if (wa < N0 + N_HID + N1 + N_OUT) b1_d[wa - N0 - N_HID - N1] = wr_data;
        end
        if (start) begin
          for (int n = 0; n < N_IN; n++) x_d[n] = x_in[n*DW +: DW];
          for (int n = 0; n < N_HID; n++) h_d[n] = hiddenlayerout[n*DW +: DW];
          for (int n = 0; n < N_OUT; n++) sm_d[n] = softmaxout[n*DW +: DW];
          real_d = realstate;
          lr_d = lr_shift;
          err_d = int'(realstate) >= N_OUT;
          byp_d = int'(realstate) >= N_OUT || (skip_hit && predictedstate == realstate);
          state_d = CHK;
        end
      end
      CHK: begin
        o_d = '0;
        i_d = '0;
        acc_d = '0;
        state_d = byp_q ? DONE : DZ1;
      end
      DZ1: begin
        dz1_d[oi] = sat(WW'(sm_q[oi]) - (oi == int'(real_q) ? WW'(ONE) : WW'(0)));
        o_d = oi == N_OUT - 1 ? '0 : o_q + CW'(1);
        state_d = oi == N_OUT - 1 ? DA0 : DZ1;
      end
      DA0: begin
        if (ii == N_OUT - 1) begin
          dz0_d[oi] = (!h_q[oi][DW-1] && |h_q[oi]) ? sat(WW'(acc_n >>> FRAC)) : '0;
          acc_d = '0;
          i_d = '0;
          o_d = oi == N_HID - 1 ? '0 : o_q + CW'(1);
          state_d = oi == N_HID - 1 ? UPD1 : DA0;
        end else begin
          acc_d = acc_n;
          i_d = i_q + CW'(1);
        end
      end
      UPD1: begin
        if (ii == N_HID) begin
          b1_d[oi] = upd;
          i_d = '0;
          o_d = oi == N_OUT - 1 ? '0 : o_q + CW'(1);
          state_d = oi == N_OUT - 1 ? UPD0 : UPD1;
        end else begin
          w1_d[oi*N_HID + ii] = upd;
          i_d = i_q + CW'(1);
        end
      end
      UPD0: begin
        if (ii == N_IN) begin
          b0_d[oi] = upd;
          i_d = '0;
          o_d = oi == N_HID - 1 ? '0 : o_q + CW'(1);
          state_d = oi == N_HID - 1 ? DONE : UPD0;
        end else begin
          w0_d[oi*N_IN + ii] = upd;
          i_d = i_q + CW'(1);
        end
      end
      default: begin
        err_d = 1'b0;
        byp_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      o_q <= '0;
      i_q <= '0;
      acc_q <= '0;
      w0_q <= '{default: '0};
      b0_q <= '{default: '0};
      w1_q <= '{default: '0};
      b1_q <= '{default: '0};
      x_q <= '{default: '0};
      h_q <= '{default: '0};
      sm_q <= '{default: '0};
      dz1_q <= '{default: '0};
      dz0_q <= '{default: '0};
      real_q <= '0;
      lr_q <= '0;
      err_q <= 1'b0;
      byp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q <= o_d;
      i_q <= i_d;
      acc_q <= acc_d;
      w0_q <= w0_d;
      b0_q <= b0_d;
      w1_q <= w1_d;
      b1_q <= b1_d;
      x_q <= x_d;
      h_q <= h_d;
      sm_q <= sm_d;
      dz1_q <= dz1_d;
      dz0_q <= dz0_d;
      real_q <= real_d;
      lr_q <= lr_d;
      err_q <= err_d;
      byp_q <= byp_d;
    end
  end
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    err = state_q == DONE && err_q;
    for (int n = 0; n < N0; n++) W0[n*DW +: DW] = w0_q[n];
    for (int n = 0; n < N_HID; n++) b0[n*DW +: DW] = b0_q[n];
    for (int n = 0; n < N1; n++) W1[n*DW +: DW] = w1_q[n];
    for (int n = 0; n < N_OUT; n++) b1[n*DW +: DW] = b1_q[n];
  end
endmodule

// File: tb/tb_mlp_backprop_engine.sv
// tb_mlp_backprop_engine: self-checking bench for mlp_backprop_engine against an arithmetic model
module tb_mlp_backprop_engine;
  localparam int DW = 16, N_IN = 2, N_HID = 8, N_OUT = 3, SW = 2, AW = 6;
  localparam int N0 = N_IN*N_HID, N1 = N_OUT*N_HID, NP = N0 + N_HID + N1 + N_OUT;
  localparam int W1B = N0 + N_HID, B1 = W1B + N1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, skip_hit = 1'b0, wr_en = 1'b0;
  logic [3:0] lr_shift = '0;
  logic [SW-1:0] predictedstate = '0, realstate = '0;
  logic [N_IN*DW-1:0] x_in = '0;
  logic [N_HID*DW-1:0] hiddenlayerout = '0;
  logic [N_OUT*DW-1:0] softmaxout = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [N0*DW-1:0] W0;
  logic [N_HID*DW-1:0] b0;
  logic [N1*DW-1:0] W1;
  logic [N_OUT*DW-1:0] b1;
  logic busy, done, err;
  int tests = 0, fails = 0;
  int m[NP];
  int xv[N_IN], hv[N_HID], smv[N_OUT];
  typedef struct {bit sk; int pr; int rl; int lr; int lat; bit er;} vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  mlp_backprop_engine dut (
    .clk(clk), .rst(rst), .start(start), .skip_hit(skip_hit), .lr_shift(lr_shift),
    .predictedstate(predictedstate), .realstate(realstate), .x_in(x_in),
    .hiddenlayerout(hiddenlayerout), .softmaxout(softmaxout), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .W0(W0), .b0(b0), .W1(W1), .b1(b1),
    .busy(busy), .done(done), .err(err)
  );
  function automatic int sat16(longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : int'(v);
  endfunction
  function automatic int dut_p(int a);
    logic signed [DW-1:0] v;
    if (a < N0) v = W0[a*DW +: DW];
    else if (a < W1B) v = b0[(a-N0)*DW +: DW];
    else if (a < B1) v = W1[(a-W1B)*DW +: DW];
    else v = b1[(a-B1)*DW +: DW];
    return int'(v);
  endfunction
  task automatic check(string nm, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic check_params(string nm);
    for (int a = 0; a < NP; a++) check($sformatf("%s param[%0d]", nm, a), dut_p(a), m[a]);
  endtask
  // One SGD step computed straight from the gradient formulas on the flat model array.
  task automatic model_step(bit sk, int pr, int rl, int lr);
    int dz1[N_OUT], dz0[N_HID];
    longint acc;
    if (rl >= N_OUT || (sk && pr == rl)) return;
    for (int k = 0; k < N_OUT; k++) dz1[k] = sat16(smv[k] - (k == rl ? 1024 : 0));
    for (int j = 0; j < N_HID; j++) begin
      acc = 0;
      for (int k = 0; k < N_OUT; k++) acc += longint'(m[W1B + k*N_HID + j]) * dz1[k];
      dz0[j] = hv[j] > 0 ? sat16(acc >>> 10) : 0;
    end
    for (int k = 0; k < N_OUT; k++) begin
      for (int j = 0; j < N_HID; j++)
        m[W1B + k*N_HID + j] = sat16(m[W1B + k*N_HID + j] - ((longint'(dz1[k]) * hv[j]) >>> (10 + lr)));
      m[B1 + k] = sat16(m[B1 + k] - (longint'(dz1[k]) >>> lr));
    end
    for (int j = 0; j < N_HID; j++) begin
      for (int i = 0; i < N_IN; i++)
        m[j*N_IN + i] = sat16(m[j*N_IN + i] - ((longint'(dz0[j]) * xv[i]) >>> (10 + lr)));
      m[N0 + j] = sat16(m[N0 + j] - (longint'(dz0[j]) >>> lr));
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < NP; a++) m[a] = 0;
  endtask
  task automatic write_param(int a, int v);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(v);
    @(negedge clk);
    wr_en = 1'b0;
    m[a] = sat16(v);
  endtask
  task automatic drive_inputs(bit sk, int pr, int rl, int lr);
    skip_hit = sk;
    predictedstate = SW'(pr);
    realstate = SW'(rl);
    lr_shift = 4'(lr);
    for (int i = 0; i < N_IN; i++) x_in[i*DW +: DW] = DW'(xv[i]);
    for (int j = 0; j < N_HID; j++) hiddenlayerout[j*DW +: DW] = DW'(hv[j]);
    for (int k = 0; k < N_OUT; k++) softmaxout[k*DW +: DW] = DW'(smv[k]);
  endtask
  task automatic wait_done(string nm, int exp_lat, bit exp_err);
    int lat = -1;
    int e = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        e = int'(err);
        break;
      end
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " err"}, e, int'(exp_err));
    @(negedge clk);
    check({nm, " done pulse width"}, int'(done), 0);
  endtask
  task automatic run_step(string nm, bit sk, int pr, int rl, int lr, int exp_lat, bit exp_err,
                          bit wr = 1'b0, int wa = 0, int wv = 0);
    @(negedge clk);
    drive_inputs(sk, pr, rl, lr);
    start = 1'b1;
    if (wr) begin
      wr_en = 1'b1;
      wr_addr = AW'(wa);
      wr_data = DW'(wv);
      m[wa] = wv;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    check({nm, " busy"}, int'(busy), 1);
    model_step(sk, pr, rl, lr);
    wait_done(nm, exp_lat, exp_err);
    check_params(nm);
  endtask
  task automatic rand_inputs();
    for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(0, 4095)) - 2048;
    for (int j = 0; j < N_HID; j++) hv[j] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 4096));
    for (int k = 0; k < N_OUT; k++) smv[k] = int'($urandom_range(0, 1024));
  endtask
  task automatic rand_params();
    for (int a = 0; a < NP; a++)
      write_param(a, ($urandom_range(0, 7) == 0) ? 32000 : int'($urandom_range(0, 8191)) - 4096);
  endtask
  task automatic case1_inputs();
    xv = '{1024, 2048};
    smv = '{512, 256, 256};
    for (int j = 0; j < N_HID; j++) hv[j] = 1024;
  endtask
  initial begin
    int seen;
    tbl = '{'{0, 0, 0, 0, 79, 0}, '{1, 1, 1, 1, 1, 0}, '{1, 0, 1, 2, 79, 0},
            '{0, 2, 2, 3, 79, 0}, '{0, 0, 3, 0, 1, 1}, '{1, 3, 3, 1, 1, 1}};
    do_reset();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);
    check_params("reset");
    rand_params();
    for (int t = 0; t < 6; t++) begin
      rand_inputs();
      run_step($sformatf("tbl%0d", t), tbl[t].sk, tbl[t].pr, tbl[t].rl, tbl[t].lr, tbl[t].lat, tbl[t].er);
    end
    do_reset();
    case1_inputs();
    run_step("case1", 0, 0, 0, 0, 79, 0);
    check("case1 W1[0][3]", dut_p(W1B + 3), 512);
    check("case1 W1[2][7]", dut_p(W1B + 2*N_HID + 7), -256);
    check("case1 b1[0]", dut_p(B1), 512);
    check("case1 b1[1]", dut_p(B1 + 1), -256);
    check("case1 W0[5][1]", dut_p(11), 0);
    do_reset();
    case1_inputs();
    for (int j = 0; j < N_HID; j++) write_param(W1B + j, 1024);
    run_step("case2", 0, 1, 0, 0, 79, 0);
    check("case2 W0[2][0]", dut_p(4), 512);
    check("case2 W0[2][1]", dut_p(5), 1024);
    check("case2 b0[6]", dut_p(N0 + 6), 512);
    check("case2 W1[0][0]", dut_p(W1B), 1536);
    do_reset();
    case1_inputs();
    hv[3] = 0;
    for (int j = 0; j < N_HID; j++) write_param(W1B + j, 1024);
    run_step("case3", 0, 0, 0, 0, 79, 0);
    check("case3 W0[3][0]", dut_p(6), 0);
    check("case3 W0[3][1]", dut_p(7), 0);
    check("case3 b0[3]", dut_p(N0 + 3), 0);
    check("case3 W0[4][1]", dut_p(9), 1024);
    do_reset();
    case1_inputs();
    smv[0] = 0;
    hv[0] = 4096;
    write_param(W1B, 32700);
    run_step("case4", 0, 1, 0, 0, 79, 0);
    check("case4 W1[0][0] sat", dut_p(W1B), 32767);
    do_reset();
    case1_inputs();
    write_param(W1B + 1, 700);
    run_step("wr+start", 0, 2, 1, 1, 79, 0, 1'b1, W1B, 2048);
    rand_inputs();
    @(negedge clk);
    drive_inputs(0, 0, 2, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_step(0, 0, 2, 0);
    repeat (5) @(negedge clk);
    check("busy-write busy", int'(busy), 1);
    wr_en = 1'b1;
    wr_addr = AW'(0);
    wr_data = DW'(12345);
    @(negedge clk);
    wr_en = 1'b0;
    wait_done("busy-write", 73, 0);
    check_params("busy-write");
    rand_params();
    rand_inputs();
    @(negedge clk);
    drive_inputs(0, 1, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < NP; a++) m[a] = 0;
    check("midreset busy", int'(busy), 0);
    check_params("midreset");
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("midreset no done", seen, 0);
    rand_params();
    for (int t = 0; t < 25; t++) begin
      bit sk;
      int pr, rl, lr;
      sk = 1'($urandom_range(0, 1));
      pr = int'($urandom_range(0, 2));
      rl = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      lr = int'($urandom_range(0, 6));
      rand_inputs();
      run_step($sformatf("rand%0d", t), sk, pr, rl, lr, (rl >= N_OUT || (sk && pr == rl)) ? 1 : 79, rl >= N_OUT);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
